// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive packet path.
//   uart_pkt_state_t          : packet controller FSM states
//   UART_SOF_DEFAULT          : default start-of-frame byte
//   UART_PKT_MAX_LEN_DEFAULT  : default maximum payload length / buffer depth
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } uart_pkt_state_t;

    localparam logic [7:0]  UART_SOF_DEFAULT         = 8'h7E;
    localparam int unsigned UART_PKT_MAX_LEN_DEFAULT = 16;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer for the packet controller: DEPTH x 8 register array.
// Ports:
//   clk            : clock
//   we/waddr/wdata : single write port, written on the rising edge when we=1
//   raddr/rdata    : combinational read port
// Contents are not reset; the controller never reads a slot before writing it.
module uart_pkt_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind the UART receiver. Assembles SOF, LEN, payload,
// checksum frames from the receiver's byte strobe, buffers and checks the
// payload, then streams it out over valid/ready. Bad frames are discarded
// and reported on single-cycle error pulses.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   rx_done, rx_data        : receiver byte flag (2 cycles high) and byte
//   out_valid/ready/data/last : payload stream to the consumer
//   err_len, err_csum, err_timeout, err_overrun : registered 1-cycle pulses
// Optional feature macro UART_RX_PKT_STATS_EN adds saturating 16-bit
// good_cnt (completed drains) and bad_cnt (error pulses) outputs.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_HUNT    | waiting for SOF, other bytes ignored
// ST_LEN     | SOF seen, waiting for LEN byte
// ST_PAYLOAD | collecting LEN payload bytes into the buffer
// ST_CSUM    | waiting for the checksum byte
// ST_DRAIN   | streaming the buffered payload to the consumer
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN      = UART_PKT_MAX_LEN_DEFAULT,
    parameter logic [7:0]  SOF          = UART_SOF_DEFAULT,
    parameter int unsigned TIMEOUT_CLKS = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        err_len,
    output logic        err_csum,
    output logic        err_timeout,
    output logic        err_overrun
`ifdef UART_RX_PKT_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CNT_W-1:0] IDLE_TC   = CNT_W'(TIMEOUT_CLKS);

    uart_pkt_state_t  state_q, state_d;
    logic             rx_done_q;
    logic [7:0]       len_q, len_d;
    logic [7:0]       csum_q, csum_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             err_len_q, err_len_d;
    logic             err_csum_q, err_csum_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_overrun_q, err_overrun_d;
    logic             drain_done;

    logic             stb;
    logic [7:0]       len_m1;
    logic             last_beat;
    logic             len_ok;
    logic             in_frame;
    logic             buf_we;
    logic [7:0]       buf_rdata;

    assign stb       = rx_done & ~rx_done_q;
    assign len_m1    = len_q - 8'd1;
    assign last_beat = (8'(rd_idx_q) == len_m1);
    assign len_ok    = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);
    assign in_frame  = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) ||
                       (state_q == ST_CSUM);

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (IDX_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_idx_q),
        .wdata (rx_data),
        .raddr (rd_idx_q),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        csum_d        = csum_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        idle_d        = '0;
        err_len_d     = 1'b0;
        err_csum_d    = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        drain_done    = 1'b0;
        buf_we        = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                if (stb && (rx_data == SOF)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (stb) begin
                    len_d = rx_data;
                    if (len_ok) begin
                        state_d  = ST_PAYLOAD;
                        wr_idx_d = '0;
                        csum_d   = rx_data;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (stb) begin
                    buf_we = 1'b1;
                    csum_d = csum_q ^ rx_data;
                    if (8'(wr_idx_q) == len_m1) begin
                        state_d = ST_CSUM;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (stb) begin
                    if (rx_data == csum_q) begin
                        state_d  = ST_DRAIN;
                        rd_idx_d = '0;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready && last_beat) begin
                    // Final handshake frees the controller this edge, so a
                    // coincident byte is treated as if we were already hunting.
                    drain_done = 1'b1;
                    state_d    = (stb && (rx_data == SOF)) ? ST_LEN : ST_HUNT;
                end else begin
                    if (out_ready) begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                    err_overrun_d = stb;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // A byte on the terminal-count edge wins: stb keeps idle_d at 0.
        if (in_frame && !stb) begin
            if (idle_q == IDLE_TC) begin
                err_timeout_d = 1'b1;
                state_d       = ST_HUNT;
            end else begin
                idle_d = idle_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            rx_done_q     <= 1'b0;
            len_q         <= '0;
            csum_q        <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            idle_q        <= '0;
            err_len_q     <= 1'b0;
            err_csum_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_done_q     <= rx_done;
            len_q         <= len_d;
            csum_q        <= csum_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            idle_q        <= idle_d;
            err_len_q     <= err_len_d;
            err_csum_q    <= err_csum_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign out_valid   = (state_q == ST_DRAIN);
    assign out_data    = out_valid ? buf_rdata : 8'd0;
    assign out_last    = out_valid && last_beat;
    assign err_len     = err_len_q;
    assign err_csum    = err_csum_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

`ifdef UART_RX_PKT_STATS_EN
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] bad_cnt_q, bad_cnt_d;
    logic        any_err_d;

    assign any_err_d = err_len_d | err_csum_d | err_timeout_d | err_overrun_d;

    always_comb begin
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (drain_done && (good_cnt_q != 16'hFFFF)) begin
            good_cnt_d = good_cnt_q + 16'd1;
        end
        if (any_err_d && (bad_cnt_q != 16'hFFFF)) begin
            bad_cnt_d = bad_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign good_cnt = good_cnt_q;
    assign bad_cnt  = bad_cnt_q;
`else
    logic unused_drain_done;
    assign unused_drain_done = drain_done;
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
`timescale 1ns/1ps
module tb_uart_rx_pkt_ctrl;

    localparam int T = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid, out_last;
    logic [7:0] out_data;
    logic       err_len, err_csum, err_timeout, err_overrun;
`ifdef UART_RX_PKT_STATS_EN
    logic [15:0] good_cnt, bad_cnt;
`endif

    uart_rx_pkt_ctrl #(
        .MAX_LEN      (16),
        .SOF          (8'h7E),
        .TIMEOUT_CLKS (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .err_len     (err_len),
        .err_csum    (err_csum),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
`ifdef UART_RX_PKT_STATS_EN
        ,
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stb_cyc  = 0;
    int len_cyc  = 0;
    int to_cyc   = 0;
    int cnt_len = 0, cnt_csum = 0, cnt_to = 0, cnt_ovr = 0, valid_cycles = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_v;
    int         xfer_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_len) begin cnt_len++; len_cyc = cyc; end
            if (err_csum) cnt_csum++;
            if (err_timeout) begin cnt_to++; to_cyc = cyc; end
            if (err_overrun) cnt_ovr++;
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                n_assert++;
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got data %h last %b, required no transfer", out_data, out_last);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({out_last, out_data} !== exp_v) begin
                        n_fail++;
                        $display("FAIL sb_data: got last %b data %h, required last %b data %h",
                                 out_last, out_data, exp_v[8], exp_v[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        stb_cyc = cyc;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d bytes still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #23;
        n_assert++;
        if ({out_valid, out_last, out_data, err_len, err_csum, err_timeout, err_overrun} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {out_valid, out_last, out_data, err_len, err_csum, err_timeout, err_overrun});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if ({out_valid, err_len, err_csum, err_timeout, err_overrun} !== 5'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b, required 00000",
                     {out_valid, err_len, err_csum, err_timeout, err_overrun});
        end
    endtask

    task automatic test_basic();
        int b_l = cnt_len, b_c = cnt_csum, b_t = cnt_to, b_o = cnt_ovr;
        int s;
        out_ready = 1'b1;
        xfer_cyc.delete();
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        s = stb_cyc;
        wait_drain();
        n_assert++;
        if (xfer_cyc.size() != 3 || xfer_cyc[0] != s || xfer_cyc[1] != s + 1 || xfer_cyc[2] != s + 2) begin
            n_fail++;
            $display("FAIL basic_timing: got %0d transfers starting at cycle offset %0d, required 3 at offsets 0,1,2",
                     xfer_cyc.size(), (xfer_cyc.size() > 0) ? xfer_cyc[0] - s : -1);
        end
        n_assert++;
        if (cnt_len != b_l || cnt_csum != b_c || cnt_to != b_t || cnt_ovr != b_o) begin
            n_fail++;
            $display("FAIL basic_errs: got len %0d csum %0d to %0d ovr %0d new pulses, required 0",
                     cnt_len - b_l, cnt_csum - b_c, cnt_to - b_t, cnt_ovr - b_o);
        end
    endtask

    task automatic test_len();
        int b_l = cnt_len, b_c = cnt_csum;
        out_ready = 1'b1;
        send_byte(8'h7E); send_byte(8'h00);
        n_assert++;
        if (cnt_len - b_l != 1 || len_cyc != stb_cyc) begin
            n_fail++;
            $display("FAIL len_zero: got %0d pulse cycles at offset %0d, required 1 at offset 0",
                     cnt_len - b_l, len_cyc - stb_cyc);
        end
        send_byte(8'h7E); send_byte(8'h11);
        n_assert++;
        if (cnt_len - b_l != 2) begin
            n_fail++;
            $display("FAIL len_too_big: got %0d pulse cycles total, required 2", cnt_len - b_l);
        end
        exp_q.push_back({1'b1, 8'hAA});
        send_byte(8'h7E); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hAB);
        wait_drain();
        n_assert++;
        if (cnt_len - b_l != 2 || cnt_csum != b_c) begin
            n_fail++;
            $display("FAIL len_recover: got len %0d csum %0d pulses, required 2 and 0",
                     cnt_len - b_l, cnt_csum - b_c);
        end
    endtask

    task automatic test_csum();
        int b_c = cnt_csum, b_v = valid_cycles;
        out_ready = 1'b1;
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'hFF);
        repeat (5) @(posedge clk);
        #1;
        n_assert++;
        if (cnt_csum - b_c != 1 || valid_cycles != b_v) begin
            n_fail++;
            $display("FAIL csum_bad: got %0d csum pulse cycles, %0d valid cycles, required 1 and 0",
                     cnt_csum - b_c, valid_cycles - b_v);
        end
    endtask

    task automatic test_timeout();
        int b_t = cnt_to;
        int s;
        int d;
        out_ready = 1'b1;
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'h01);
        s = stb_cyc;
        for (int i = 0; i < T + 50 && cnt_to == b_t; i++) @(negedge clk);
        d = to_cyc - s;
        n_assert++;
        if (cnt_to == b_t || d < T || d > T + 3) begin
            n_fail++;
            $display("FAIL timeout_fire: got %0d pulses, delay %0d, required 1 pulse with delay %0d..%0d",
                     cnt_to - b_t, d, T, T + 3);
        end
        repeat (30) @(posedge clk);
        #1;
        n_assert++;
        if (cnt_to - b_t != 1) begin
            n_fail++;
            $display("FAIL timeout_once: got %0d pulse cycles, required 1", cnt_to - b_t);
        end
        // Slow but legal frame: gaps just under the limit must not time out.
        exp_q.push_back({1'b1, 8'hAA});
        send_byte(8'h7E); send_byte(8'h01);
        repeat (T - 20) @(posedge clk);
        send_byte(8'hAA);
        repeat (T - 20) @(posedge clk);
        send_byte(8'hAB);
        wait_drain();
        n_assert++;
        if (cnt_to - b_t != 1) begin
            n_fail++;
            $display("FAIL timeout_near: got %0d pulse cycles, required 1", cnt_to - b_t);
        end
    endtask

    task automatic test_overrun();
        int b_o = cnt_ovr, b_l = cnt_len, b_c = cnt_csum;
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        send_byte(8'h55);
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if (cnt_ovr - b_o != 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: got %0d pulse cycles, required 1", cnt_ovr - b_o);
        end
        n_assert++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_hold: got valid %b data %h last %b, required 1 11 0",
                     out_valid, out_data, out_last);
        end
        out_ready = 1'b1;
        wait_drain();
        n_assert++;
        if (cnt_ovr - b_o != 1 || cnt_len != b_l || cnt_csum != b_c) begin
            n_fail++;
            $display("FAIL overrun_errs: got ovr %0d len %0d csum %0d, required 1 0 0",
                     cnt_ovr - b_o, cnt_len - b_l, cnt_csum - b_c);
        end
    endtask

    task automatic test_back_to_back();
        int b_o = cnt_ovr, b_l = cnt_len, b_c = cnt_csum;
        out_ready = 1'b0;
        exp_q.push_back({1'b1, 8'hCC});
        send_byte(8'h7E); send_byte(8'h01); send_byte(8'hCC); send_byte(8'hCD);
        repeat (2) @(posedge clk);
        #1;
        // Final handshake and SOF strobe land on the same edge.
        rx_data = 8'h7E;
        rx_done = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        exp_q.push_back({1'b1, 8'hDD});
        send_byte(8'h01); send_byte(8'hDD); send_byte(8'hDC);
        wait_drain();
        n_assert++;
        if (cnt_ovr != b_o || cnt_len != b_l || cnt_csum != b_c) begin
            n_fail++;
            $display("FAIL b2b_errs: got ovr %0d len %0d csum %0d, required 0 0 0",
                     cnt_ovr - b_o, cnt_len - b_l, cnt_csum - b_c);
        end
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_assert++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            n_fail++;
            $display("FAIL rst_pre: got valid %b data %h, required 1 22", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_assert++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drop: got out_valid %b, required 0", out_valid);
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b1, 8'hBB});
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA);
        send_byte(8'hBB); send_byte(8'h13);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len();
        test_csum();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
# uart_rx_pkt_ctrl

Packet controller behind the UART receiver. It takes the receiver's per-byte `done`/`data_out` strobe and assembles framed packets of the form SOF, LEN, payload, checksum. Each payload is buffered and checked, then released to the downstream consumer over a valid/ready stream; malformed, stalled or overrun frames are discarded and reported on single-cycle error pulses.

## Interface
- `MAX_LEN`, 16: maximum payload bytes (1..255); sets buffer depth.
- `SOF`, 8'h7E: start-of-frame byte.
- `TIMEOUT_CLKS`, 1000: maximum idle clocks between bytes inside a frame.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_done` in 1: receiver byte-complete flag; high for 2 consecutive cycles per byte.
- `rx_data` in 8: receiver byte; stable while `rx_done`=1.
- `out_valid` out 1: payload byte available.
- `out_ready` in 1: consumer accepts byte.
- `out_data` out 8: payload byte.
- `out_last` out 1: qualifies the final payload byte.
- `err_len` out 1: pulse when LEN is 0 or greater than `MAX_LEN`.
- `err_csum` out 1: pulse on checksum mismatch.
- `err_timeout` out 1: pulse on inter-byte timeout.
- `err_overrun` out 1: pulse when a byte is dropped during drain.

## Operation
- Byte strobe `stb` = `rx_done & ~rx_done_q`. Only the rising edge counts, so the 2-cycle `done` yields exactly one byte.
- States: HUNT, LEN, PAYLOAD, CSUM, DRAIN. Reset state is HUNT.
- HUNT: on `stb`, if `rx_data`==`SOF` go to LEN; any other byte is ignored silently.
- LEN: on `stb`, latch `len`.
  - 1..`MAX_LEN`: go to PAYLOAD with `wr_idx`=0 and `csum`=`rx_data`.
  - Otherwise pulse `err_len` and go to HUNT.
- PAYLOAD: on `stb`, write `buf[wr_idx]`, `csum ^= rx_data`, `wr_idx++`. When `wr_idx`==`len-1`, go to CSUM.
- CSUM: on `stb`, if `rx_data`==`csum` go to DRAIN with `rd_idx`=0. Otherwise pulse `err_csum` and go to HUNT.
- Checksum is the 8-bit XOR of the LEN byte and all payload bytes.
- DRAIN:
  - `out_valid`=1, `out_data`=`buf[rd_idx]`, `out_last`=(`rd_idx`==`len-1`).
  - On `out_valid & out_ready`: `rd_idx++`. The last transfer goes to HUNT.
  - `stb` during DRAIN: byte dropped, `err_overrun` pulses.
- Timeout: the idle counter clears on every `stb` and counts in LEN, PAYLOAD and CSUM. On reaching `TIMEOUT_CLKS`: pulse `err_timeout` and go to HUNT. It is held at 0 in HUNT and DRAIN.
- Counter widths are `$clog2(TIMEOUT_CLKS+1)` and `$clog2(MAX_LEN)`; no wrap is possible within a legal frame.

## Timing
- Reset values: all outputs 0, state HUNT, `rx_done_q`=0, indices and counters 0.
- `stb` is combinational from `rx_done` and the registered `rx_done_q`. State and data update on the same edge on which `stb`=1.
- `out_valid` rises on the clock after the edge that accepted a good checksum byte, so the first data byte is visible 1 cycle after the CSUM `stb`.
- Drain throughput is 1 byte per cycle with `out_ready` held high. `out_data` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- Error pulses are registered, exactly 1 cycle wide, and appear on the cycle after the offending edge.
- Boundary conditions:
  - `stb` and timeout terminal count on the same edge: the byte wins and the counter clears.
  - Final DRAIN handshake and `stb` on the same edge: the byte is evaluated as in HUNT, with no overrun.
  - `rst_n` low mid-frame or mid-drain: the packet is discarded and `out_valid` drops immediately.

## Configuration
- `UART_RX_PKT_STATS_EN` defined: adds outputs `good_cnt` out 16 and `bad_cnt` out 16.
  - `good_cnt` increments on each completed drain; `bad_cnt` increments on any error pulse.
  - Both saturate at 16'hFFFF and reset to 0.
- Without the macro these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_pkt_state_t` (HUNT, LEN, PAYLOAD, CSUM, DRAIN).
  - constant `UART_SOF_DEFAULT`=8'h7E.
  - constant `UART_PKT_MAX_LEN_DEFAULT`=16.
- One sub-module, `uart_pkt_buf`: `MAX_LEN`x8 register array with a single write port (`we`, `waddr`, `wdata`) and a combinational read port (`raddr` → `rdata`). The FSM, checksum and timeout logic stay in the top module.

## Test plan
- Frame 7E 03 11 22 33 03 (checksum 03^11^22^33=03), `out_ready`=1 → `out_data` 11, 22, 33 on 3 consecutive cycles; `out_last` on 33; no error pulses.
- Frame 7E 00 → `err_len` pulse 1 cycle; state HUNT; a following 7E 01 AA AB drains AA with `out_last`=1.
- Frame 7E 02 01 02 FF → `err_csum` pulse; `out_valid` never asserts.
- 7E 02 01, then no byte for `TIMEOUT_CLKS` clocks → `err_timeout` exactly once, then HUNT.
- Good frame with `out_ready`=0 and a byte arriving during DRAIN → `err_overrun` pulse; the full payload still drains unchanged once `out_ready`=1.
- `rst_n` asserted during DRAIN after 1 of 3 bytes → `out_valid`=0 immediately; a fresh good frame after release is delivered intact.
